// File: rtl/calc_operand_sequencer.sv
// Keypad-driven operand entry and ALU command sequencer: START 2 cycles after '=', RESULT_VALID the cycle after DONE.
// No backpressure on keys: digits past MAX_DIGITS and every key while BUSY are dropped; DONE is honoured only in WAIT.
module calc_operand_sequencer #(
  parameter int MAX_DIGITS = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  input  logic        DONE,
  input  logic        COUT,
  input  logic [39:0] S,
  input  logic [39:0] QBAJO,
  output logic [39:0] registro_A,
  output logic [39:0] registro_B,
  output logic [1:0]  estado,
  output logic        listoB,
  output logic        START,
  output logic [1:0]  OP,
  output logic [39:0] RESULT,
  output logic        RESULT_VALID,
  output logic        CARRY,
  output logic        BUSY,
  output logic        ERR
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // State code carries {BUSY, listoB, estado, tag}, so those outputs come straight off the register.
  typedef enum logic [4:0] {
    ENT_A = 5'b00010,
    ENT_B = 5'b00110,
    LOAD0 = 5'b10100,
    LOAD1 = 5'b10101,
    LOAD2 = 5'b11000,
    WAIT  = 5'b10000,
    SHOW  = 5'b00000
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;
  logic [TW-1:0] timer;
  logic          is_digit;
  logic          is_op;
  logic          is_eq;
  logic          is_clr;
  logic [1:0]    op_code;
  logic [39:0]   digit_ext;
  logic [39:0]   a_next;
  logic [39:0]   b_next;

  assign estado = state[2:1];
  assign listoB = state[3];
  assign BUSY   = state[4];

  assign is_digit  = KEY_VALID && (KEY_CODE <= 4'd9);
  assign is_op     = KEY_VALID && (KEY_CODE >= 4'd10) && (KEY_CODE <= 4'd13);
  assign is_eq     = KEY_VALID && (KEY_CODE == 4'd14);
  assign is_clr    = KEY_VALID && (KEY_CODE == 4'd15);
  // code-10 modulo 4 equals code+2 modulo 4 for codes 10..13
  assign op_code   = KEY_CODE[1:0] + 2'd2;
  assign digit_ext = {36'd0, KEY_CODE};
  assign a_next    = (registro_A << 3) + (registro_A << 1) + digit_ext;
  assign b_next    = (registro_B << 3) + (registro_B << 1) + digit_ext;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ENT_A;
      registro_A   <= '0;
      registro_B   <= '0;
      cnt_a        <= '0;
      cnt_b        <= '0;
      timer        <= '0;
      OP           <= '0;
      RESULT       <= '0;
      CARRY        <= 1'b0;
      ERR          <= 1'b0;
      START        <= 1'b0;
      RESULT_VALID <= 1'b0;
    end else begin
      START        <= 1'b0;
      RESULT_VALID <= 1'b0;
      if (is_clr && !BUSY) begin
        state      <= ENT_A;
        registro_A <= '0;
        registro_B <= '0;
        cnt_a      <= '0;
        cnt_b      <= '0;
        OP         <= '0;
        RESULT     <= '0;
        CARRY      <= 1'b0;
        ERR        <= 1'b0;
      end else begin
        case (state)
          ENT_A: begin
            if (is_digit && (cnt_a < CW'(MAX_DIGITS))) begin
              registro_A <= a_next;
              cnt_a      <= cnt_a + CW'(1);
            end else if (is_op) begin
              OP         <= op_code;
              registro_B <= '0;
              cnt_b      <= '0;
              state      <= ENT_B;
            end
          end
          ENT_B: begin
            if (is_digit && (cnt_b < CW'(MAX_DIGITS))) begin
              registro_B <= b_next;
              cnt_b      <= cnt_b + CW'(1);
            end else if (is_op && (cnt_b == '0)) begin
              OP <= op_code;
            end else if (is_eq) begin
              if ((OP == 2'b11) && (registro_B == '0)) begin
                ERR   <= 1'b1;
                state <= SHOW;
              end else if (cnt_b != '0) begin
                state <= LOAD0;
              end
            end
          end
          LOAD0: begin
            START <= 1'b1;
            state <= LOAD1;
          end
          LOAD1: state <= LOAD2;
          LOAD2: begin
            timer <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (DONE) begin
              RESULT       <= OP[1] ? QBAJO : S;
              CARRY        <= ~OP[1] & COUT;
              RESULT_VALID <= 1'b1;
              state        <= SHOW;
            end else if (timer == TW'(TIMEOUT - 1)) begin
              // ERR lands exactly TIMEOUT cycles after the first WAIT cycle
              ERR   <= 1'b1;
              state <= SHOW;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          SHOW: begin
            if (!ERR && is_digit) begin
              registro_A <= digit_ext;
              cnt_a      <= CW'(1);
              state      <= ENT_A;
            end else if (!ERR && is_op) begin
              registro_A <= RESULT;
              cnt_a      <= CW'(MAX_DIGITS);
              OP         <= op_code;
              registro_B <= '0;
              cnt_b      <= '0;
              state      <= ENT_B;
            end
          end
          default: state <= ENT_A;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed keypad sequences with a result scoreboard; a negedge monitor pops expected RESULT/CARRY on each RESULT_VALID.
module tb_calc_operand_sequencer;

  localparam int MAX_DIGITS = 12;
  localparam int TIMEOUT    = 255;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        KEY_VALID = 1'b0;
  logic [3:0]  KEY_CODE = 4'd0;
  logic        DONE = 1'b0;
  logic        COUT = 1'b0;
  logic [39:0] S = '0;
  logic [39:0] QBAJO = '0;
  logic [39:0] registro_A, registro_B, RESULT;
  logic [1:0]  estado, OP;
  logic        listoB, START, RESULT_VALID, CARRY, BUSY, ERR;

  typedef struct {
    logic [39:0] res;
    logic        carry;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   rv_cnt = 0;
  int   s0;

  calc_operand_sequencer #(.MAX_DIGITS(MAX_DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .DONE(DONE), .COUT(COUT), .S(S), .QBAJO(QBAJO),
    .registro_A(registro_A), .registro_B(registro_B), .estado(estado),
    .listoB(listoB), .START(START), .OP(OP), .RESULT(RESULT),
    .RESULT_VALID(RESULT_VALID), .CARRY(CARRY), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic key(input logic [3:0] c);
    KEY_VALID = 1'b1;
    KEY_CODE  = c;
    @(posedge CLK); #1;
    KEY_VALID = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic alu_done(input int dly, input logic [39:0] s, input logic [39:0] q, input logic c);
    S = s; QBAJO = q; COUT = c;
    cycles(dly);
    DONE = 1'b1;
    @(posedge CLK); #1;
    DONE = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (START) start_cnt++;
      if (RESULT_VALID) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result_valid: got RESULT=0x%0h expected no pulse", RESULT);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_result", RESULT, e.res);
          chk("sb_carry", CARRY, e.carry);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cycles(3);
    RST = 1'b0;
    chk("rst_A", registro_A, 0);
    chk("rst_B", registro_B, 0);
    chk("rst_estado", estado, 2'b01);
    chk("rst_outs", {listoB, START, OP, RESULT_VALID, CARRY, BUSY, ERR}, 0);
    chk("rst_result", RESULT, 0);

    // 12 + 7 with carry-out asserted by the ALU
    key(1); key(2);
    chk("acc_A12", registro_A, 12);
    key(10);
    chk("entB_estado", estado, 2'b11);
    chk("op_add", OP, 0);
    key(7);
    chk("acc_B7", registro_B, 7);
    s0 = start_cnt;
    key(14);
    chk("load0", {START, BUSY, estado, listoB}, {1'b0, 1'b1, 2'b10, 1'b0});
    cycles(1);
    chk("load1_start", {START, estado, listoB}, {1'b1, 2'b10, 1'b0});
    cycles(1);
    chk("load2", {START, estado, listoB}, {1'b0, 2'b00, 1'b1});
    cycles(1);
    chk("wait", {BUSY, listoB}, 2'b10);
    exp_q.push_back('{res: 40'd19, carry: 1'b1});
    alu_done(2, 40'd19, 40'h55, 1'b1);
    chk("add_result", RESULT, 19);
    chk("show_idle", {BUSY, estado}, {1'b0, 2'b00});
    cycles(2);
    chk("one_start", start_cnt, s0 + 1);
    chk("one_rv", rv_cnt, 1);

    // chain from 19, then reset mid-WAIT
    key(10); key(1); key(14);
    cycles(3);
    chk("chain_A", registro_A, 19);
    chk("chain_B", registro_B, 1);
    chk("chain_busy", BUSY, 1);
    RST = 1'b1;
    cycles(1);
    RST = 1'b0;
    chk("midrst_outs", {registro_A, registro_B, RESULT, OP, START, RESULT_VALID, CARRY, BUSY, ERR, listoB}, 0);
    chk("midrst_estado", estado, 2'b01);
    s0 = start_cnt;
    DONE = 1'b1; cycles(1); DONE = 1'b0;
    cycles(4);
    chk("no_start_after_rst", start_cnt, s0);
    chk("done_ignored", RESULT, 0);

    // 25 * 4 selects QBAJO, carry forced low
    key(2); key(5); key(12); key(4);
    chk("op_mul", OP, 2);
    key(14);
    cycles(3);
    exp_q.push_back('{res: 40'd100, carry: 1'b0});
    alu_done(1, 40'hFF, 40'd100, 1'b1);
    chk("mul_result", RESULT, 100);
    chk("mul_carry", CARRY, 0);

    // clear, then divide by zero
    key(15);
    chk("clr_result", RESULT, 0);
    key(9); key(13); key(0);
    s0 = start_cnt;
    key(14);
    chk("div0_err", ERR, 1);
    chk("div0_show", {BUSY, estado}, {1'b0, 2'b00});
    cycles(4);
    chk("div0_no_start", start_cnt, s0);
    key(5);
    chk("err_digit_ignored", registro_A, 9);
    key(10);
    chk("err_op_ignored", estado, 2'b00);
    key(15);
    chk("clr_err", ERR, 0);
    chk("clr_regs", {registro_A, registro_B, RESULT}, 0);
    chk("clr_estado", estado, 2'b01);

    // 13 nines: the 13th digit is dropped
    for (int i = 0; i < 13; i++) key(9);
    chk("max_digits", registro_A, 40'hE8D4A50FFF);

    // 999999999999 - 3 with no DONE: timeout, and 'C' ignored while busy
    key(11); key(3); key(14);
    cycles(3);
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge CLK); #1;
      if (i == 10) begin
        KEY_VALID = 1'b1; KEY_CODE = 4'd15;
      end else begin
        KEY_VALID = 1'b0;
      end
      if (i == TIMEOUT - 1) chk("pre_timeout", {ERR, BUSY}, 2'b01);
      if (i == TIMEOUT)     chk("timeout", {ERR, BUSY}, 2'b10);
    end
    chk("busy_clr_ignored", registro_A, 40'hE8D4A50FFF);
    chk("timeout_result", RESULT, 0);
    key(15);
    chk("final_clr", ERR, 0);
    cycles(2);
    chk("sb_empty", exp_q.size(), 0);
    chk("total_rv", rv_cnt, 2);
    chk("total_start", start_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
